// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encoding and line-level constants for the FIFO-fed UART transmitter.
// No logic; types and constants only.
// The PARITY state exists only when FIFO_UART_TX_PARITY_EN is defined.
package fifo_uart_tx_pkg;

  // Line levels for the framing bits
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Explicit encodings keep the state values stable whether or not parity is built
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: counts 0..clks_per_bit-1 and flags the last cycle of each period.
// tick is a combinational decode of the registered count, valid in the same cycle.
// clr holds the count at zero; the counter wraps to zero on its own after tick.
module baud_gen #(
  parameter int clks_per_bit = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running period counter, restarted by clr or at the end of each period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Serialises words from a first-word-fall-through FIFO as UART frames (start, data LSB first, [parity], stop).
// Frame = (width+2)*clks_per_bit cycles (+clks_per_bit with parity); one IDLE cycle between back-to-back frames.
// Pulls one word per frame via re only when idle; optional parity bit under macro FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int width        = 16,
  parameter int clks_per_bit = 868
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [width-1:0] data_in,
  output logic             re,
  output logic             tx,
  output logic             busy
);

  localparam int BW = $clog2(width + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

  state_t           state;
  logic [width-1:0] shreg;
  logic [width-1:0] shifted;
  logic [BW-1:0]    bitcnt;
  logic             tick;
  logic             clr;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             par_bit;
`endif

  // The pop and the load share one edge, so re is a decode of the registered
  // state and the FIFO flag; rst gates it so reset silences reads at once.
  assign re = (state == IDLE) && !fifo_empty && !rst;

  // The counter sits at zero while idle; every later state entry coincides
  // with a period wrap, so each state starts with a fresh count.
  assign clr = (state == IDLE);

  assign shifted = shreg >> 1;

  baud_gen #(
    .clks_per_bit(clks_per_bit)
  ) u_baud_gen (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  // Frame sequencer; tx and busy are loaded with the value of the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tx     <= STOP_BIT;
      busy   <= 1'b0;
      shreg  <= '0;
      bitcnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state  <= START;
            shreg  <= data_in;
            bitcnt <= '0;
            tx     <= START_BIT;
            busy   <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_bit <= ^data_in;
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shifted;
            if (bitcnt == LAST_BIT) begin
              bitcnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              state  <= PARITY;
              tx     <= par_bit;
`else
              state  <= STOP;
              tx     <= STOP_BIT;
`endif
            end else begin
              bitcnt <= bitcnt + 1'b1;
              tx     <= shifted[0];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= STOP_BIT;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            tx    <= STOP_BIT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= STOP_BIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx (width=16, clks_per_bit=4) against a queue-based FIFO and frame model.
// Each sampled cycle is compared with an expected line waveform built from the popped word.
// Parity expectations follow FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;

  localparam int W   = 16;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = W + 3;
`else
  localparam int NBITS = W + 2;
`endif
  localparam int F = NBITS * CPB;

  logic         clk;
  logic         rst;
  logic         fifo_empty;
  logic [W-1:0] data_in;
  logic         re;
  logic         tx;
  logic         busy;

  logic [W-1:0] fq[$];
  logic         exp_tx[$];
  int           re_cyc[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           pushes = 0;
  int           pops = 0;
  int           busy_cnt = 0;
  bit           pop_pending = 0;

  fifo_uart_tx #(
    .width(W),
    .clks_per_bit(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .data_in   (data_in),
    .re        (re),
    .tx        (tx),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    data_in    = (fq.size() != 0) ? fq[0] : 16'hDEAD;
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    pushes++;
    refresh();
  endtask

  // Expected line: start, data LSB first, optional even parity, stop; CPB cycles each
  function automatic void queue_frame(input logic [W-1:0] w);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(w[i]);
`ifdef FIFO_UART_TX_PARITY_EN
    bits.push_back(^w);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < CPB; k++) exp_tx.push_back(bits[i]);
    end
  endfunction

  task automatic monitor();
    bit want_re;
    if (rst) begin
      exp_tx.delete();
      pop_pending = 0;
      return;
    end
    want_re = (exp_tx.size() == 0) && (fq.size() != 0);
    if (exp_tx.size() != 0) begin
      chk("tx_frame", tx, exp_tx.pop_front());
      chk("busy_frame", busy, 1);
    end else begin
      chk("tx_idle", tx, 1);
      chk("busy_idle", busy, 0);
    end
    if (busy === 1'b1) busy_cnt++;
    chk("re", re, want_re);
    if (re === 1'b1 && fq.size() != 0) begin
      pop_pending = 1;
      re_cyc.push_back(cyc);
      queue_frame(fq[0]);
    end
  endtask

  // One clock: sample at negedge, then let the FIFO model pop just after posedge
  task automatic step();
    logic [W-1:0] tmp;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (pop_pending) begin
      tmp = fq.pop_front();
      pops++;
      pop_pending = 0;
    end
    refresh();
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || fq.size() != 0) && n < max) begin
      step();
      n++;
    end
    chk("drain_done", (exp_tx.size() == 0 && fq.size() == 0), 1);
  endtask

  initial begin
    logic [W-1:0] w;
    int n;

    rst = 1'b0;
    fifo_empty = 1'b1;
    data_in = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_re", re, 0);
    repeat (3) step();
    #1 rst = 1'b0;

    // Empty FIFO: no reads, line idle
    repeat (200) step();

    // Single word
    re_cyc.delete();
    busy_cnt = 0;
    push(16'hA5C3);
    drain(300);
    chk("single_re_count", re_cyc.size(), 1);
    chk("single_busy_len", busy_cnt, F);

    // Back-to-back words
    re_cyc.delete();
    push(16'h0001);
    push(16'hFFFF);
    drain(400);
    chk("b2b_re_count", re_cyc.size(), 2);
    if (re_cyc.size() == 2) chk("b2b_gap", re_cyc[1] - re_cyc[0], F + 1);
    chk("b2b_empty", fifo_empty, 1);

    // Reset in the middle of DATA bit 5
    re_cyc.delete();
    w = 16'h1234;
    push(w);
    push(16'hBEEF);
    n = 0;
    while (re_cyc.size() == 0 && n < 50) begin
      step();
      n++;
    end
    chk("mf_started", re_cyc.size(), 1);
    repeat (CPB + 5 * CPB + 2) step();
    chk("mf_bit5", tx, w[5]);
    chk("mf_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("mf_rst_tx", tx, 1);
    chk("mf_rst_busy", busy, 0);
    chk("mf_rst_re", re, 0);
    repeat (3) begin
      step();
      chk("re_in_rst", re, 0);
    end
    #1 rst = 1'b0;
    re_cyc.delete();
    drain(300);
    chk("mf_next_re_count", re_cyc.size(), 1);
    chk("mf_pops", pops, pushes);

    // Randomized traffic, including words arriving mid-frame
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 3);
      repeat (n) push(W'($urandom));
      repeat ($urandom_range(0, 120)) step();
    end
    drain(4000);
    chk("rand_pops", pops, pushes);
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
